// File: rtl/rr_slot_alloc.sv
// rr_slot_alloc: round-robin slot allocator over a W-entry occupancy vector.
// Grants one free slot per cycle over a valid/ready port and retires slots
// through a free port. The circular find-first-zero search starts at ptr-1
// and walks downward: ptr-1, ptr-2, ..., ptr (mod W).
// Optional macro RR_SLOT_ALLOC_ERR_EN builds a sticky protocol-error flag
// (double free, request while full). Without it err_o is tied low.
module rr_slot_alloc #(
    parameter int W     = 32,
    parameter int INFER = 0
) (
    input  logic                   clk,
    input  logic                   arst_n,
    input  logic                   flush_i,
    input  logic                   alloc_vld_i,
    output logic                   alloc_rdy_o,
    output logic [$clog2(W)-1:0]   alloc_id_o,
    input  logic                   free_vld_i,
    input  logic [$clog2(W)-1:0]   free_id_i,
    output logic [W-1:0]           occ_o,
    output logic [$clog2(W):0]     cnt_o,
    output logic                   full_o,
    output logic                   err_o
);
    localparam int LW = $clog2(W);
    localparam int CW = LW + 1;

    logic [W-1:0]  occ_reg;
    logic [LW-1:0] ptr_reg;
    logic [CW-1:0] cnt_reg;

    // rot[k] is the occupancy of slot (ptr-1-k) mod W, i.e. the k-th slot in search order
    logic [W-1:0]  rot;
    logic [LW-1:0] first_k;
    logic          any_free;
    logic [LW-1:0] grant_id;

    generate
        if (INFER != 0) begin : g_infer_rot
            // Let synthesis build the rotator from indexed selects.
            for (genvar gi = 0; gi < W; gi++) begin : g_bit
                assign rot[gi] = occ_reg[ptr_reg - LW'(1) - LW'(gi)];
            end
        end else begin : g_explicit_rot
            // Log-depth barrel rotator on the bit-reversed occupancy vector:
            // reversing turns the downward walk into an upward one, then
            // rotating left by ptr puts slot ptr-1 at position 0.
            logic [(LW+1)*W-1:0] stage_bus;
            for (genvar gi = 0; gi < W; gi++) begin : g_rev
                assign stage_bus[gi] = occ_reg[W-1-gi];
            end
            for (genvar gi = 0; gi < LW; gi++) begin : g_stage
                for (genvar gj = 0; gj < W; gj++) begin : g_bit
                    localparam int SRC = (gj - (1 << gi) + W) % W;
                    assign stage_bus[(gi+1)*W + gj] = ptr_reg[gi] ? stage_bus[gi*W + SRC]
                                                                  : stage_bus[gi*W + gj];
                end
            end
            assign rot = stage_bus[LW*W +: W];
        end
    endgenerate

    // Priority encoder: lowest rotated position holding a zero.
    always_comb begin
        first_k  = '0;
        any_free = 1'b0;
        for (int k = W - 1; k >= 0; k--) begin
            if (!rot[k]) begin
                first_k  = LW'(k);
                any_free = 1'b1;
            end
        end
    end

    // Map the rotated position back to a slot index.
    assign grant_id = ptr_reg - LW'(1) - first_k;

    logic          fire;
    logic          free_hit;
    logic [W-1:0]  set_mask;
    logic [W-1:0]  clr_mask;

    assign alloc_rdy_o = any_free & ~flush_i;
    assign alloc_id_o  = grant_id;
    assign fire        = alloc_vld_i & alloc_rdy_o;
    assign free_hit    = free_vld_i & occ_reg[free_id_i] & ~flush_i;
    assign set_mask    = fire     ? (W'(1) << grant_id)  : '0;
    assign clr_mask    = free_hit ? (W'(1) << free_id_i) : '0;

    // Occupancy, search pointer and allocated-slot count.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            occ_reg <= '0;
            ptr_reg <= '0;
            cnt_reg <= '0;
        end else if (flush_i) begin
            occ_reg <= '0;
            ptr_reg <= '0;
            cnt_reg <= '0;
        end else begin
            // Grant and free never hit the same slot: the grant targets a zero, the free a one.
            occ_reg <= (occ_reg | set_mask) & ~clr_mask;
            if (fire) begin
                ptr_reg <= grant_id;
            end
            cnt_reg <= cnt_reg + CW'(fire) - CW'(free_hit);
        end
    end

    assign occ_o  = occ_reg;
    assign cnt_o  = cnt_reg;
    assign full_o = &occ_reg;

`ifdef RR_SLOT_ALLOC_ERR_EN
    logic err_reg;
    logic err_set;

    assign err_set = ~flush_i & ((free_vld_i & ~occ_reg[free_id_i]) | (alloc_vld_i & full_o));

    // Sticky error flag; only the asynchronous reset clears it (flush does not).
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            err_reg <= 1'b0;
        end else if (err_set) begin
            err_reg <= 1'b1;
        end
    end

    assign err_o = err_reg;
`else
    assign err_o = 1'b0;
`endif

endmodule
